// File: rtl/alu_serial_seq.sv
// Bit-serial ALU: AND/OR/ADD/XOR (with B inversion for SUB), one bit per clock, LSB first.
// Optional OVERFLOW output enabled by defining ALU_SERIAL_OVF_EN.
module alu_serial_seq #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BINVERT,
  input  logic [1:0]       OPERATION,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             COUT,
`ifdef ALU_SERIAL_OVF_EN
  output logic             OVERFLOW,
`endif
  output logic             ZERO
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StFin} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             binv_q, binv_d;
  logic [1:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic bit_a, bit_mb, bit_res, carry_maj, last_bit;

`ifdef ALU_SERIAL_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    bit_a     = a_q[cnt_q];
    bit_mb    = b_q[cnt_q] ^ binv_q;
    carry_maj = (bit_a & bit_mb) | (bit_a & carry_q) | (bit_mb & carry_q);
    last_bit  = (cnt_q == CntW'(WIDTH - 1));
    unique case (op_q)
      2'b00:   bit_res = bit_a & bit_mb;
      2'b01:   bit_res = bit_a | bit_mb;
      2'b10:   bit_res = bit_a ^ bit_mb ^ carry_q;
      default: bit_res = bit_a ^ bit_mb;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    binv_d   = binv_q;
    op_d     = op_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
`ifdef ALU_SERIAL_OVF_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (START) begin
          a_d     = A;
          b_d     = B;
          binv_d  = BINVERT;
          op_d    = OPERATION;
          carry_d = BINVERT;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        // New bit enters at the MSB; after WIDTH shifts bit i sits at RESULT[i].
        result_d = WIDTH'({bit_res, result_q} >> 1);
        carry_d  = carry_maj;
        cnt_d    = cnt_q + CntW'(1);
        if (last_bit) begin
          cnt_d   = '0;
          state_d = StFin;
`ifdef ALU_SERIAL_OVF_EN
          ovf_d   = (op_q == 2'b10) & (carry_q ^ carry_maj);
`endif
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      binv_q   <= 1'b0;
      op_q     <= 2'b00;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      binv_q   <= binv_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

`ifdef ALU_SERIAL_OVF_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign OVERFLOW = ovf_q;
`endif

  assign BUSY   = (state_q == StShift);
  assign DONE   = (state_q == StFin);
  assign RESULT = result_q;
  assign COUT   = carry_q;
  assign ZERO   = (result_q == '0);

endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq: directed vectors queue expectations, a monitor checks DONE.
module tb_alu_serial_seq;

  localparam int unsigned WIDTH = 24;

  logic             CLK;
  logic             RESET;
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BINVERT;
  logic [1:0]       OPERATION;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] RESULT;
  logic             COUT;
  logic             ZERO;
`ifdef ALU_SERIAL_OVF_EN
  logic             OVERFLOW;
`endif

  alu_serial_seq #(.WIDTH(WIDTH)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .A         (A),
    .B         (B),
    .BINVERT   (BINVERT),
    .OPERATION (OPERATION),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .RESULT    (RESULT),
    .COUT      (COUT),
`ifdef ALU_SERIAL_OVF_EN
    .OVERFLOW  (OVERFLOW),
`endif
    .ZERO      (ZERO)
  );

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             cout;
    logic             zero;
    logic             ovf;
    int               done_cyc;
    string            name;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  bit   have_last = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, want);
    end
  endtask

  // Monitor: pops one expectation per DONE pulse and checks held outputs while idle.
  always @(negedge CLK) begin
    if (RESET) begin
      have_last = 1'b0;
    end else if (DONE) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(DONE), 32'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_result"}, 32'(RESULT), 32'(e.res));
        check({e.name, "_cout"}, 32'(COUT), 32'(e.cout));
        check({e.name, "_zero"}, 32'(ZERO), 32'(e.zero));
        check({e.name, "_done_cycle"}, 32'(cyc), 32'(e.done_cyc));
`ifdef ALU_SERIAL_OVF_EN
        check({e.name, "_overflow"}, 32'(OVERFLOW), 32'(e.ovf));
`endif
        last_exp  = e;
        have_last = 1'b1;
      end
    end else if (!BUSY && have_last) begin
      check({last_exp.name, "_hold_result"}, 32'(RESULT), 32'(last_exp.res));
      check({last_exp.name, "_hold_cout"}, 32'(COUT), 32'(last_exp.cout));
    end
  end

  // Called just after a negedge; returns at the negedge following the accept edge.
  task automatic launch(input string nm, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic binv, input logic [1:0] op, input bit push,
                        input logic [WIDTH-1:0] res, input logic cout, input logic ovf);
    exp_t e;
    A         = a;
    B         = b;
    BINVERT   = binv;
    OPERATION = op;
    START     = 1'b1;
    if (push) begin
      e.res      = res;
      e.cout     = cout;
      e.zero     = (res == '0);
      e.ovf      = ovf;
      e.done_cyc = cyc + WIDTH + 1;
      e.name     = nm;
      exp_q.push_back(e);
    end
    @(negedge CLK);
    START = 1'b0;
    check({nm, "_busy_after_start"}, 32'(BUSY), 32'(1));
    check({nm, "_no_early_done"}, 32'(DONE), 32'(0));
  endtask

  task automatic wait_done(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < WIDTH + 4 && !seen; i++) begin
      @(negedge CLK);
      if (DONE) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_done_timeout: no DONE, required DONE within %0d cycles", nm, WIDTH + 4);
    end
  endtask

  initial begin
    RESET     = 1'b1;
    START     = 1'b0;
    A         = '0;
    B         = '0;
    BINVERT   = 1'b0;
    OPERATION = 2'b00;
    #2;
    check("reset_busy", 32'(BUSY), 32'(0));
    check("reset_done", 32'(DONE), 32'(0));
    check("reset_result", 32'(RESULT), 32'(0));
    check("reset_cout", 32'(COUT), 32'(0));
    check("reset_zero", 32'(ZERO), 32'(1));
    repeat (2) @(negedge CLK);

    // START on the very first edge after reset release.
    RESET = 1'b0;
    launch("add_1_2", 24'h000001, 24'h000002, 1'b0, 2'b10, 1'b1, 24'h000003, 1'b0, 1'b0);
    wait_done("add_1_2");

    // Back-to-back launches from the idle cycle after DONE.
    @(negedge CLK);
    launch("sub_5_5", 24'h000005, 24'h000005, 1'b1, 2'b10, 1'b1, 24'h000000, 1'b1, 1'b0);
    wait_done("sub_5_5");
    @(negedge CLK);
    launch("add_wrap", 24'hFFFFFF, 24'h000001, 1'b0, 2'b10, 1'b1, 24'h000000, 1'b1, 1'b0);
    wait_done("add_wrap");
    @(negedge CLK);
    launch("add_ovf", 24'h7FFFFF, 24'h000001, 1'b0, 2'b10, 1'b1, 24'h800000, 1'b0, 1'b1);
    wait_done("add_ovf");
    @(negedge CLK);
    launch("xor", 24'hF0F0F0, 24'h0FF0FF, 1'b0, 2'b11, 1'b1, 24'hFF000F, 1'b1, 1'b0);
    wait_done("xor");
    @(negedge CLK);
    launch("and", 24'hF0F0F0, 24'h0FF0FF, 1'b0, 2'b00, 1'b1, 24'h00F0F0, 1'b1, 1'b0);
    wait_done("and");
    @(negedge CLK);
    launch("or", 24'hF0F0F0, 24'h0FF0FF, 1'b0, 2'b01, 1'b1, 24'hFFF0FF, 1'b1, 1'b0);
    wait_done("or");
    @(negedge CLK);
    launch("sub_borrow", 24'h000003, 24'h000005, 1'b1, 2'b10, 1'b1, 24'hFFFFFE, 1'b0, 1'b0);
    wait_done("sub_borrow");
    @(negedge CLK);
    launch("xnor_binv", 24'h123456, 24'h00FF00, 1'b1, 2'b11, 1'b1, 24'hED34A9, 1'b1, 1'b0);
    wait_done("xnor_binv");

    // START pulsed at bit 5 with different operands must be ignored.
    @(negedge CLK);
    launch("start_ignored", 24'h000010, 24'h000020, 1'b0, 2'b10, 1'b1, 24'h000030, 1'b0, 1'b0);
    repeat (5) @(negedge CLK);
    A         = 24'hFFFFFF;
    B         = 24'hFFFFFF;
    BINVERT   = 1'b1;
    OPERATION = 2'b01;
    START     = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done("start_ignored");

    // Reset at bit 10 aborts with no DONE; next START completes normally.
    @(negedge CLK);
    launch("aborted", 24'hABCDEF, 24'h111111, 1'b0, 2'b10, 1'b0, 24'h0, 1'b0, 1'b0);
    repeat (10) @(negedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    check("abort_busy", 32'(BUSY), 32'(0));
    check("abort_done", 32'(DONE), 32'(0));
    check("abort_result", 32'(RESULT), 32'(0));
    check("abort_zero", 32'(ZERO), 32'(1));
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    launch("after_abort", 24'h100000, 24'h0ABCDE, 1'b0, 2'b10, 1'b1, 24'h1ABCDE, 1'b0, 1'b0);
    wait_done("after_abort");

    repeat (WIDTH + 4) @(negedge CLK);
    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_serial_seq.md
ALU_SERIAL_SEQ -- requirements
Module: alu_serial_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24, meaning operand and result width in bits.
REQ-002 The block SHALL have port CLK  input  1  rising-edge clock.
REQ-003 The block SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port START  input  1  request to begin an operation, sampled at the CLK edge.
REQ-005 The block SHALL have port A  input  WIDTH  operand A, captured on an accepted START.
REQ-006 The block SHALL have port B  input  WIDTH  operand B, captured on an accepted START.
REQ-007 The block SHALL have port BINVERT  input  1  invert B and force the initial carry-in to 1, captured on an accepted START.
REQ-008 The block SHALL have port OPERATION  input  2  operation code (00 AND, 01 OR, 10 ADD, 11 XOR), captured on an accepted START.
REQ-009 The block SHALL have port BUSY  output  1  high while bits are being processed.
REQ-010 The block SHALL have port DONE  output  1  one-cycle pulse marking RESULT/COUT/ZERO valid.
REQ-011 The block SHALL have port RESULT  output  WIDTH  registered result.
REQ-012 The block SHALL have port COUT  output  1  final carry out of the bit-serial adder chain.
REQ-013 The block SHALL have port ZERO  output  1  high when RESULT equals 0.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT and FIN.
REQ-015 In IDLE with START=1 at an edge, the block SHALL capture A, B, BINVERT and OPERATION, load carry=BINVERT, clear the bit counter, and enter SHIFT.
REQ-016 Any START that arrives while the FSM is in SHIFT or FIN SHALL be ignored, and the captured operands SHALL not change.
REQ-017 Each SHIFT edge SHALL process one bit, LSB first, with mB = B[i] XOR BINVERT, using the same one-bit slice semantics as the datapath ALU slice.
REQ-018 The per-bit result SHALL be A&mB for 00, A|mB for 01, A^mB^carry for 10, and A^mB for 11.
REQ-019 The carry SHALL update every SHIFT edge as the majority of (A[i], mB, carry), for all operation codes.
REQ-020 Result bits SHALL shift into the result register from the MSB side, so that bit i lands in RESULT[i] after WIDTH shifts.
REQ-021 After the WIDTH-th SHIFT edge, the FSM SHALL enter FIN; DONE SHALL be 1 for exactly that one cycle, and the next edge SHALL return the FSM to IDLE.
REQ-022 Latency SHALL be WIDTH+1 edges from the START-accept edge to the cycle in which DONE is high; the back-to-back issue interval SHALL be WIDTH+2 cycles.
REQ-023 BUSY SHALL be 1 exactly in SHIFT and 0 in IDLE and FIN.
REQ-024 RESULT, COUT and ZERO SHALL hold their values from DONE until the next accepted START; during SHIFT they are don't-care.
REQ-025 COUT SHALL equal the carry after bit WIDTH-1; for SUB (OPERATION=10, BINVERT=1), COUT=1 SHALL mean no borrow.
REQ-026 ZERO SHALL be derived combinationally from the RESULT register.

Reset
REQ-027 RESET=1 SHALL immediately force: state IDLE, BUSY=0, DONE=0, RESULT=0, COUT=0, carry=0, counter=0, and ZERO=1.
REQ-028 RESET asserted mid-operation SHALL abort the operation with no DONE pulse.
REQ-029 A START sampled on the first edge after RESET deasserts SHALL be accepted.

Configuration
REQ-030 With macro ALU_SERIAL_OVF_EN defined, the block SHALL add port OVERFLOW (output, 1 bit), equal to carry-into-MSB XOR COUT for OPERATION=10 and 0 for other codes; it SHALL be reset to 0 and held like COUT.
REQ-031 Without ALU_SERIAL_OVF_EN, the block SHALL have no OVERFLOW port and no related logic.

Verification
REQ-032 ADD: A=0x000001, B=0x000002, OP=10, BINVERT=0 -> DONE at edge 25, RESULT=0x000003, COUT=0, ZERO=0.
REQ-033 SUB: A=0x000005, B=0x000005, OP=10, BINVERT=1 -> RESULT=0x000000, ZERO=1, COUT=1.
REQ-034 Wrap: A=0xFFFFFF, B=0x000001, ADD -> RESULT=0x000000, COUT=1; with ALU_SERIAL_OVF_EN, A=0x7FFFFF, B=0x000001 -> OVERFLOW=1.
REQ-035 Logic: A=0xF0F0F0, B=0x0FF0FF, OP=11 -> RESULT=0xFF000F; OP=00 -> 0x00F0F0; OP=01 -> 0xFFF0FF.
REQ-036 Hazards: START pulsed at SHIFT bit 5 -> ignored, original result produced; RESET at bit 10 -> BUSY=0, RESULT=0, no DONE, and the next START completes normally.
